// File: rtl/datamem_pkg.sv
// Shared constants, command encodings and index extraction for the data_mem block.
package datamem_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 24;
  localparam int IDX_LSB = 8;
  localparam int DEPTH   = 256;
  localparam int IDX_W   = $clog2(DEPTH);

  localparam logic [1:0] EN_DM_LOAD  = 2'b10;
  localparam logic [1:0] EN_DM_STORE = 2'b11;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [DATA_W-1:0] word_t;

  // Only the index field selects a word; every other address bit is ignored.
  function automatic idx_t addr_to_idx(input addr_t addr);
    return addr[IDX_LSB +: IDX_W];
  endfunction

endpackage

// File: rtl/datamem_ram.sv
// 256 x 16 storage array: synchronous write port, combinational read of the indexed word.
// Define DATAMEM_CLEAR_EN to have the asynchronous reset clear every word to zero.
module datamem_ram
  import datamem_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  idx_t  idx,
  input  word_t wr_data,
  output word_t rd_data
);

  word_t mem [DEPTH];

`ifdef DATAMEM_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= wr_data;
    end
  end
`else
  // NOTE: the array is deliberately left out of reset so the tools can map it onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wr_data;
    end
  end

  logic unused_rst_n;
  assign unused_rst_n = rst_n;
`endif

  assign rd_data = mem[idx];

endmodule

// File: rtl/data_mem.sv
// Data memory for the CPU load/store path: command decode, index extraction and the load register.
// Optional DATAMEM_CLEAR_EN makes reset also clear the storage array.
module data_mem
  import datamem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] store_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        en_dm,
  output logic [DATA_W-1:0] load_in
);

  idx_t  idx;
  logic  wr_en;
  logic  rd_en;
  word_t rd_data;

  assign idx   = addr_to_idx(addr);
  assign wr_en = (en_dm == EN_DM_STORE);
  assign rd_en = (en_dm == EN_DM_LOAD);

  datamem_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .idx     (idx),
    .wr_data (store_in),
    .rd_data (rd_data)
  );

  // Load and store are mutually exclusive, so the read never sees a same-edge write.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_in <= '0;
    end else if (rd_en) begin
      load_in <= rd_data;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: a reference array predicts each load, checked one edge later.
// Honours DATAMEM_CLEAR_EN to match the RTL build.
module tb_data_mem;
  import datamem_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] store_in;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        en_dm;
  logic [DATA_W-1:0] load_in;

  data_mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .store_in (store_in),
    .addr     (addr),
    .en_dm    (en_dm),
    .load_in  (load_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    word_t val;
  } exp_t;

  exp_t  exp_q[$];
  word_t model [DEPTH];
  bit    valid [DEPTH];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus from a falling edge; ends on the next falling edge.
  task automatic op(input logic [1:0] cmd, input addr_t a, input word_t d, input string tag);
    idx_t i;
    exp_t e;
    i        = addr_to_idx(a);
    en_dm    = cmd;
    addr     = a;
    store_in = d;
    if (cmd == EN_DM_STORE) begin
      model[i] = d;
      valid[i] = 1'b1;
    end else if (cmd == EN_DM_LOAD) begin
      e.tag = tag;
      e.val = model[i];
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic st(input addr_t a, input word_t d);
    op(EN_DM_STORE, a, d, "store");
  endtask

  task automatic ld(input addr_t a, input string tag);
    op(EN_DM_LOAD, a, $urandom_range(0, 16'hFFFF), tag);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
`ifdef DATAMEM_CLEAR_EN
      model[i] = '0;
      valid[i] = 1'b1;
`else
      model[i] = 'x;
      valid[i] = 1'b0;
`endif
    end
  endtask

  // Monitor: every load edge produces one result, compared 1 time unit after the edge.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && en_dm == EN_DM_LOAD) begin
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
        check("sb_underflow", load_in, 16'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check(e.tag, load_in, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idx_t  ri;
    addr_t ra;
    word_t rd;

    rst_n    = 1'b0;
    en_dm    = 2'b00;
    addr     = '0;
    store_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_load_in", load_in, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DATAMEM_CLEAR_EN
    ld(24'h000100, "clear_after_reset");
`endif

    // Store then load the same word on the following cycle.
    st(24'h000400, 16'h0004);
    ld(24'h000400, "store_then_load");

    // Hold: idle commands with changing address/data must not disturb anything.
    op(2'b00, 24'h000455, 16'h1234, "idle");
    check("hold_00", load_in, 16'h0004);
    op(2'b01, 24'hFF04FF, 16'h5678, "idle");
    check("hold_01", load_in, 16'h0004);
    op(2'b00, 24'h00A000, 16'h9ABC, "idle");
    check("hold_00b", load_in, 16'h0004);
    ld(24'h000400, "hold_mem_unchanged");

    // Aliasing: only addr[15:8] matters.
    st(24'h000800, 16'h0808);
    st(24'h000700, 16'hBEEF);
    ld(24'hAB07CD, "alias_hit");
    ld(24'h000800, "alias_neighbour");
    ld(24'hFF04FF, "alias_idx4");

    // Back-to-back stores and loads.
    st(24'h000100, 16'h1111);
    st(24'h000200, 16'h2222);
    ld(24'h000100, "b2b_idx1");
    ld(24'h000200, "b2b_idx2");

    // Index boundaries.
    st(24'h00FF00, 16'hFFFF);
    st(24'h000000, 16'hA5A5);
    ld(24'h00FF00, "bound_idx_ff");
    ld(24'h000000, "bound_idx_00");
    ld(24'hFFFFFF, "bound_alias_ff");

    // Random mix over a handful of words, only loading words with known content.
    for (int n = 0; n < 200; n++) begin
      ri = idx_t'($urandom_range(0, 7)) ^ idx_t'(8'hF8 * $urandom_range(0, 1));
      ra = {8'($urandom), ri, 8'($urandom)};
      rd = word_t'($urandom);
      case ($urandom_range(0, 2))
        0:       st(ra, rd);
        1:       if (valid[ri]) ld(ra, "random_load"); else st(ra, rd);
        default: op(2'($urandom_range(0, 1)), ra, rd, "idle");
      endcase
    end

    // Asynchronous reset mid-cycle after a non-zero load.
    st(24'h003300, 16'hC3C3);
    ld(24'h003300, "pre_reset_load");
    op(2'b00, 24'h0, 16'h0, "idle");
    @(posedge clk);
    #2;
    en_dm = EN_DM_STORE;
    addr  = 24'h003300;
    store_in = 16'h7777;
    rst_n = 1'b0;
    #1;
    check("async_reset_load_in", load_in, 16'h0000);
    model_reset();
    @(negedge clk);
    en_dm = 2'b00;
    @(negedge clk);
    check("reset_hold", load_in, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DATAMEM_CLEAR_EN
    ld(24'h000100, "clear_after_reset2");
    ld(24'h003300, "clear_discard_store");
`endif
    st(24'h005000, 16'h5A5A);
    ld(24'h005000, "post_reset_store_load");
    op(2'b00, 24'h0, 16'h0, "idle");
    op(2'b00, 24'h0, 16'h0, "idle");

    if (exp_q.size() != 0) begin
      check("sb_leftover", 16'(exp_q.size()), 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
